mult_pipe_hs: RTL and testbench



---
 rtl/mult_pipe_hs.sv | 124 ++++++++++++
 tb/tb_mult_pipe_hs.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake and a whole-pipeline stall.
// Optional output accumulator stage is enabled with `define MULT_PIPE_ACC_EN.
module mult_pipe_hs #(
  parameter int unsigned WA  = 20,
  parameter int unsigned WB  = 20,
  parameter int unsigned LAT = 3,
  parameter int unsigned AG  = 8,
  localparam int unsigned PW = WA + WB + AG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_tc,
  input  logic [WA-1:0] in_a,
  input  logic [WB-1:0] in_b,
`ifdef MULT_PIPE_ACC_EN
  input  logic          in_acc,
  input  logic          in_clr,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_p
);

  localparam int unsigned PL = WA + WB;

  logic          advance;
  logic          accept;
  logic [PL-1:0] ea;
  logic [PL-1:0] eb;
  logic [PL-1:0] pl;
  logic [PW-1:0] prod;

  logic [LAT-1:0] sv;
  logic [PW-1:0]  sd [LAT];

  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;
  assign accept   = in_valid & advance;

  // Low PL bits of the (WA+1)x(WB+1) product are exact, so a PL-wide multiply suffices.
  always_comb begin
    if (in_tc) begin
      ea = PL'($signed(in_a));
      eb = PL'($signed(in_b));
    end else begin
      ea = PL'(in_a);
      eb = PL'(in_b);
    end
    pl = ea * eb;
    if (in_tc) prod = PW'($signed(pl));
    else       prod = PW'(pl);
  end

  // Stage 1 registers the product; later stages are retiming registers. Bubbles carry zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv <= '0;
      for (int unsigned i = 0; i < LAT; i++) sd[i] <= '0;
    end else if (advance) begin
      sv[0] <= accept;
      sd[0] <= accept ? prod : '0;
      for (int unsigned i = 1; i < LAT; i++) begin
        sv[i] <= sv[i-1];
        sd[i] <= sv[i-1] ? sd[i-1] : '0;
      end
    end
  end

`ifdef MULT_PIPE_ACC_EN
  logic [LAT-1:0] sa;
  logic [LAT-1:0] sc;
  logic [PW-1:0]  acc;
  logic [PW-1:0]  acc_nxt;
  logic           ov;
  logic [PW-1:0]  op;

  // Accumulate/clear flags travel alongside their operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa <= '0;
      sc <= '0;
    end else if (advance) begin
      sa[0] <= accept & in_acc;
      sc[0] <= accept & in_clr;
      for (int unsigned i = 1; i < LAT; i++) begin
        sa[i] <= sa[i-1];
        sc[i] <= sc[i-1];
      end
    end
  end

  always_comb begin
    acc_nxt = acc;
    if (sc[LAT-1])      acc_nxt = sd[LAT-1];
    else if (sa[LAT-1]) acc_nxt = acc + sd[LAT-1];
  end

  // Output accumulate stage; acc only moves when a valid result leaves stage LAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ov  <= 1'b0;
      op  <= '0;
    end else if (advance) begin
      ov <= sv[LAT-1];
      if (sv[LAT-1]) begin
        acc <= acc_nxt;
        op  <= (sa[LAT-1] | sc[LAT-1]) ? acc_nxt : sd[LAT-1];
      end else begin
        op  <= '0;
      end
    end
  end

  assign out_valid = ov;
  assign out_p     = op;
`else
  assign out_valid = sv[LAT-1];
  assign out_p     = sd[LAT-1];
`endif

endmodule

// File: tb/tb_mult_pipe_hs.sv
// Directed bench for mult_pipe_hs: a cycle model of the expected output stream checks
// out_valid, out_p and in_ready every cycle. Define MULT_PIPE_ACC_EN to test the accumulator.
module tb_mult_pipe_hs;

  localparam int unsigned WA  = 20;
  localparam int unsigned WB  = 20;
  localparam int unsigned LAT = 3;
  localparam int unsigned AG  = 8;
  localparam int unsigned PW  = WA + WB + AG;
`ifdef MULT_PIPE_ACC_EN
  localparam int unsigned ELAT = LAT + 1;
`else
  localparam int unsigned ELAT = LAT;
`endif

  typedef struct packed {
    logic          tc;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [PW-1:0] p;
  } vec_t;

  localparam vec_t VECS [10] = '{
    '{1'b1, 20'hFFFFD, 20'h00007, 48'hFFFF_FFFF_FFEB},
    '{1'b0, 20'hFFFFF, 20'hFFFFF, 48'h00FF_FFE0_0001},
    '{1'b1, 20'hFFFFF, 20'hFFFFF, 48'h0000_0000_0001},
    '{1'b1, 20'h80000, 20'h80000, 48'h0040_0000_0000},
    '{1'b0, 20'h80000, 20'h80000, 48'h0040_0000_0000},
    '{1'b1, 20'h80000, 20'h00001, 48'hFFFF_FFF8_0000},
    '{1'b0, 20'h80000, 20'h00001, 48'h0000_0008_0000},
    '{1'b1, 20'h7FFFF, 20'h7FFFF, 48'h003F_FFF0_0001},
    '{1'b1, 20'h7FFFF, 20'h80000, 48'hFFC0_0008_0000},
    '{1'b0, 20'h00000, 20'h12345, 48'h0000_0000_0000}
  };

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_tc;
  logic [WA-1:0] in_a;
  logic [WB-1:0] in_b;
`ifdef MULT_PIPE_ACC_EN
  logic          in_acc;
  logic          in_clr;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_p;

  int n_chk;
  int n_fail;

  logic          mv [ELAT];
  logic [PW-1:0] md [ELAT];

  mult_pipe_hs #(.WA(WA), .WB(WB), .LAT(LAT), .AG(AG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tc     (in_tc),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef MULT_PIPE_ACC_EN
    .in_acc    (in_acc),
    .in_clr    (in_clr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(ELAT); i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
  endtask

  // Called just after a falling edge: drive, check against the model, then advance the model.
  task automatic step_now(input logic iv, input logic tc, input logic [WA-1:0] a,
                          input logic [WB-1:0] b, input logic ordy, input logic [PW-1:0] exp,
                          output logic took);
    logic adv;
    in_valid  = iv;
    in_tc     = tc;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    adv = !mv[ELAT-1] | ordy;
    check("out_valid", 64'(out_valid), 64'(mv[ELAT-1]));
    check("out_p", 64'(out_p), mv[ELAT-1] ? 64'(md[ELAT-1]) : 64'd0);
    check("in_ready", 64'(in_ready), 64'(adv));
    took = iv & adv;
    if (adv) begin
      for (int i = int'(ELAT) - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        md[i] = md[i-1];
      end
      mv[0] = took;
      md[0] = exp;
    end
  endtask

  task automatic step(input logic iv, input logic tc, input logic [WA-1:0] a,
                      input logic [WB-1:0] b, input logic ordy, input logic [PW-1:0] exp);
    logic took;
    @(negedge clk);
    step_now(iv, tc, a, b, ordy, exp, took);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b1, '0);
  endtask

`ifdef MULT_PIPE_ACC_EN
  task automatic step_acc(input logic acc, input logic clr, input logic [WA-1:0] a,
                          input logic [WB-1:0] b, input logic [PW-1:0] exp);
    logic took;
    @(negedge clk);
    in_acc = acc;
    in_clr = clr;
    step_now(1'b1, 1'b1, a, b, 1'b1, exp, took);
  endtask
`endif

  initial begin
    int   idx;
    logic ordy;
    logic took;
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_tc     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
`ifdef MULT_PIPE_ACC_EN
    in_acc    = 1'b0;
    in_clr    = 1'b0;
`endif
    model_clear();
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_p", 64'(out_p), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single signed result, no stalls: visible after the third rising edge.
    step(1'b1, 1'b1, 20'hFFFFD, 20'd7, 1'b1, 48'hFFFF_FFFF_FFEB);
    idle(int'(ELAT) + 1);

    // Ten pairs with out_ready high one cycle in three; each operand held until accepted.
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      ordy = (c % 3 == 0);
      @(negedge clk);
      if (idx < 10)
        step_now(1'b1, VECS[idx].tc, VECS[idx].a, VECS[idx].b, ordy, VECS[idx].p, took);
      else
        step_now(1'b0, 1'b0, '0, '0, ordy, '0, took);
      if (took) idx++;
    end
    idle(2);

`ifdef MULT_PIPE_ACC_EN
    step_acc(1'b0, 1'b1, 20'd2, 20'd3, 48'd6);
    step_acc(1'b1, 1'b0, 20'd4, 20'd5, 48'd26);
    step_acc(1'b1, 1'b0, 20'hFFFFF, 20'd10, 48'd16);
    step_acc(1'b0, 1'b0, 20'd1, 20'd1, 48'd1);
    step_acc(1'b1, 1'b0, 20'd0, 20'd0, 48'd16);
    @(negedge clk);
    in_acc = 1'b0;
    in_clr = 1'b0;
    idle(int'(ELAT) + 1);
`endif

    // Fill the pipeline while stalled, then reset with everything in flight.
    for (int k = 0; k < int'(ELAT); k++)
      step(1'b1, 1'b0, 20'(k + 5), 20'(k + 5), 1'b0, 48'((k + 5) * (k + 5)));
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_p", 64'(out_p), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
`ifdef MULT_PIPE_ACC_EN
    step_acc(1'b1, 1'b0, 20'd3, 20'd3, 48'd9);
`else
    step(1'b1, 1'b1, 20'd3, 20'd3, 1'b1, 48'd9);
`endif
    idle(int'(ELAT) + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
